// File: rtl/nanov_spi_mem_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// nanov_spi_pkg
// Shared definitions for the nanoV SPI memory controller: controller states,
// SPI command bytes, request size encodings, bit-count constants and small
// helpers for byte ordering and read-data assembly.
// Optional feature macro: NANOV_SPI_SEQ_FETCH_EN (adds STREAM and DESEL).
// ---------------------------------------------------------------------------
package nanov_spi_pkg;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [5:0] CMD_BITS      = 6'd8;
  localparam logic [5:0] SPI_ADDR_BITS = 6'd24;
  localparam logic [5:0] WORD_BITS     = 6'd32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_DONE
`ifdef NANOV_SPI_SEQ_FETCH_EN
    ,
    ST_STREAM,
    ST_DESEL
`endif
  } state_e;

  // Number of data bits on the wire; fetches are always full words and
  // size 11 behaves like a word.
  function automatic logic [5:0] dataBits(input logic [1:0] size, input logic fetch);
    logic [5:0] bits;
    bits = WORD_BITS;
    if (!fetch) begin
      case (size)
        SIZE_BYTE: bits = 6'd8;
        SIZE_HALF: bits = 6'd16;
        default:   bits = WORD_BITS;
      endcase
    end
    return bits;
  endfunction

  // Reverses byte order so that byte 0 (bits [7:0]) is shifted out first.
  function automatic logic [31:0] swapBytes32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // The first received byte sits highest in the shift window; rebuild the
  // little-endian value and extend from the top received byte.
  function automatic logic [31:0] assembleRead(input logic [5:0] bits,
                                               input logic signExt,
                                               input logic [31:0] w);
    logic [31:0] r;
    case (bits)
      6'd8:    r = {{24{signExt & w[7]}}, w[7:0]};
      6'd16:   r = {{16{signExt & w[7]}}, w[7:0], w[15:8]};
      default: r = swapBytes32(w);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/nanov_spi_mem_ctrl_if.sv
// ---------------------------------------------------------------------------
// nanov_spi_mem_ctrl_if
// Groups the core-side request/response handshake and the SPI pins.
//   req_*      : request from the core (valid/ready handshake)
//   resp_*     : completion pulse and read data
//   spi_*      : chip select, mode-0 clock, MOSI, MISO
// Modports: slave (the controller), master (the core / SPI-side environment).
// Optional feature macro: NANOV_SPI_SEQ_FETCH_EN (no effect on this file).
// ---------------------------------------------------------------------------
interface nanov_spi_mem_ctrl_if #(
  parameter int ADDR_BITS = 24
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_fetch;
  logic                 req_store;
  logic [1:0]           req_size;
  logic                 req_unsigned;
  logic [ADDR_BITS-1:0] req_addr;
  logic [31:0]          req_wdata;
  logic                 resp_valid;
  logic [31:0]          resp_rdata;
  logic                 spi_cs_n;
  logic                 spi_sclk;
  logic                 spi_mosi;
  logic                 spi_miso;

  modport slave (
    input  req_valid, req_fetch, req_store, req_size, req_unsigned,
           req_addr, req_wdata, spi_miso,
    output req_ready, resp_valid, resp_rdata, spi_cs_n, spi_sclk, spi_mosi
  );

  modport master (
    output req_valid, req_fetch, req_store, req_size, req_unsigned,
           req_addr, req_wdata, spi_miso,
    input  req_ready, resp_valid, resp_rdata, spi_cs_n, spi_sclk, spi_mosi
  );
endinterface

// File: rtl/nanov_spi_mem_ctrl_shifter.sv
// ---------------------------------------------------------------------------
// nanov_spi_shifter
// Bit engine for the SPI controller: two-cycle bit period (phase A sclk low,
// phase B sclk high), 32-bit MSB-first shift register and per-segment bit
// counter.
//   clk, rstn      : clock, asynchronous active-low reset
//   start_i        : begin a new segment of start_bits_i bits (phase A next)
//   load_i         : overwrite the shift register with load_data_i
//   miso_i         : serial input, shifted in at the end of each phase B
//   sclk_o, sdo_o  : SPI clock and current output bit
//   rx_word_o      : shift window including the bit being sampled now
//   last_bit_o     : high during phase B of the segment's final bit
// Optional feature macro: NANOV_SPI_SEQ_FETCH_EN (no effect on this file).
// ---------------------------------------------------------------------------
module nanov_spi_shifter (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start_i,
  input  logic [5:0]  start_bits_i,
  input  logic        load_i,
  input  logic [31:0] load_data_i,
  input  logic        miso_i,
  output logic        sclk_o,
  output logic        sdo_o,
  output logic [31:0] rx_word_o,
  output logic        last_bit_o
);

  logic        active_q;
  logic        phase_q;
  logic [5:0]  cnt_q;
  logic [5:0]  bits_q;
  logic [31:0] shreg_q;

  assign sclk_o     = active_q & phase_q;
  assign sdo_o      = shreg_q[31];
  assign rx_word_o  = {shreg_q[30:0], miso_i};
  assign last_bit_o = active_q & phase_q & (cnt_q == bits_q - 6'd1);

  // A start always restarts the bit period in phase A, even when it lands on
  // the last edge of the previous segment, so segments run back to back.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      active_q <= 1'b0;
      phase_q  <= 1'b0;
      cnt_q    <= 6'd0;
      bits_q   <= 6'd0;
    end else if (start_i) begin
      active_q <= 1'b1;
      phase_q  <= 1'b0;
      cnt_q    <= 6'd0;
      bits_q   <= start_bits_i;
    end else if (active_q) begin
      phase_q <= ~phase_q;
      if (phase_q) begin
        cnt_q <= cnt_q + 6'd1;
      end
      if (last_bit_o) begin
        active_q <= 1'b0;
      end
    end
  end

  // Shift happens on the edge closing phase B; a load on that same edge wins
  // so a new segment's data is in place for its first phase A.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shreg_q <= 32'd0;
    end else if (load_i) begin
      shreg_q <= load_data_i;
    end else if (active_q && phase_q) begin
      shreg_q <= rx_word_o;
    end
  end

endmodule

// File: rtl/nanov_spi_mem_ctrl.sv
// ---------------------------------------------------------------------------
// nanov_spi_mem_ctrl
// Memory-side responder for the nanoV core. Serves fetch/load/store requests
// from SPI flash/RAM with READ (0x03) and WRITE (0x02): 8 command bits,
// 24 address bits (MSB first), then 1/2/4 data bytes in ascending address
// order. Read data is returned little-endian and sign/zero extended.
//   clk, rstn : clock, asynchronous active-low reset
//   bus       : nanov_spi_mem_ctrl_if.slave (request, response, SPI pins)
// Parameter ADDR_BITS: request address width, sent as 24 bits.
// Optional feature macro: NANOV_SPI_SEQ_FETCH_EN -- after a fetch, chip
// select stays low (STREAM) so a fetch at the next word skips CMD/ADDR;
// any other request first deselects for one cycle (DESEL).
// ---------------------------------------------------------------------------
module nanov_spi_mem_ctrl
  import nanov_spi_pkg::*;
#(
  parameter int ADDR_BITS = 24
) (
  input logic                  clk,
  input logic                  rstn,
  nanov_spi_mem_ctrl_if.slave  bus
);

  state_e      state_q, state_d;
  logic        isStore_q, isStore_d;
  logic        signExt_q, signExt_d;
  logic [5:0]  dataBits_q, dataBits_d;
  logic [23:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
`ifdef NANOV_SPI_SEQ_FETCH_EN
  logic        isFetch_q, isFetch_d;
  logic [23:0] nextFetch_q, nextFetch_d;
`endif

  logic [ADDR_BITS-1:0] addrIn;
  logic [23:0]          reqAddr24;
  logic [7:0]           reqCmd;
  logic                 accept;
  logic                 ready;
  logic                 csN;
  logic                 mosiEn;

  logic        shStart;
  logic [5:0]  shStartBits;
  logic        shLoad;
  logic [31:0] shLoadData;
  logic        shSclk;
  logic        shSdo;
  logic [31:0] shRxWord;
  logic        shLastBit;

  assign addrIn    = bus.req_addr;
  assign reqAddr24 = 24'(addrIn);
  assign reqCmd    = (bus.req_store && !bus.req_fetch) ? CMD_WRITE : CMD_READ;
  assign accept    = bus.req_valid && ready;

  nanov_spi_shifter u_shifter (
    .clk          (clk),
    .rstn         (rstn),
    .start_i      (shStart),
    .start_bits_i (shStartBits),
    .load_i       (shLoad),
    .load_data_i  (shLoadData),
    .miso_i       (bus.spi_miso),
    .sclk_o       (shSclk),
    .sdo_o        (shSdo),
    .rx_word_o    (shRxWord),
    .last_bit_o   (shLastBit)
  );

  // Next-state logic. Each segment (CMD, ADDR, DATA) is one shifter run;
  // the next segment is started on the final phase-B edge of the previous
  // one so no idle cycles appear between them. Request fields are captured
  // on accept so the core may change its inputs afterwards.
  always_comb begin
    state_d     = state_q;
    isStore_d   = isStore_q;
    signExt_d   = signExt_q;
    dataBits_d  = dataBits_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
`ifdef NANOV_SPI_SEQ_FETCH_EN
    isFetch_d   = isFetch_q;
    nextFetch_d = nextFetch_q;
`endif
    shStart     = 1'b0;
    shStartBits = CMD_BITS;
    shLoad      = 1'b0;
    shLoadData  = 32'd0;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          shStart    = 1'b1;
          shLoad     = 1'b1;
          shLoadData = {reqCmd, reqAddr24};
          state_d    = ST_CMD;
        end
      end
      ST_CMD: begin
        if (shLastBit) begin
          shStart     = 1'b1;
          shStartBits = SPI_ADDR_BITS;
          state_d     = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (shLastBit) begin
          shStart     = 1'b1;
          shStartBits = dataBits_q;
          shLoad      = 1'b1;
          shLoadData  = isStore_q ? swapBytes32(wdata_q) : 32'd0;
          state_d     = ST_DATA;
        end
      end
      ST_DATA: begin
        if (shLastBit) begin
          rdata_d = isStore_q ? 32'd0 : assembleRead(dataBits_q, signExt_q, shRxWord);
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
`ifdef NANOV_SPI_SEQ_FETCH_EN
        if (isFetch_q) begin
          state_d     = ST_STREAM;
          nextFetch_d = addr_q + 24'd4;
        end
`endif
      end
`ifdef NANOV_SPI_SEQ_FETCH_EN
      ST_STREAM: begin
        if (bus.req_valid) begin
          if (bus.req_fetch && (reqAddr24 == nextFetch_q)) begin
            shStart     = 1'b1;
            shStartBits = WORD_BITS;
            shLoad      = 1'b1;
            shLoadData  = 32'd0;
            state_d     = ST_DATA;
          end else begin
            state_d = ST_DESEL;
          end
        end
      end
      ST_DESEL: begin
        shStart    = 1'b1;
        shLoad     = 1'b1;
        shLoadData = {(isStore_q ? CMD_WRITE : CMD_READ), addr_q};
        state_d    = ST_CMD;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      isStore_d  = bus.req_store && !bus.req_fetch;
      signExt_d  = !bus.req_unsigned && !bus.req_fetch;
      dataBits_d = dataBits(bus.req_size, bus.req_fetch);
      addr_d     = reqAddr24;
      wdata_d    = bus.req_wdata;
`ifdef NANOV_SPI_SEQ_FETCH_EN
      isFetch_d  = bus.req_fetch;
`endif
    end
  end

  // Pin and handshake decode from the current state. MOSI is only driven
  // while command, address or store data is on the wire.
  always_comb begin
    ready  = 1'b0;
    csN    = 1'b1;
    mosiEn = 1'b0;
    case (state_q)
      ST_IDLE: ready = 1'b1;
      ST_CMD, ST_ADDR: begin
        csN    = 1'b0;
        mosiEn = 1'b1;
      end
      ST_DATA: begin
        csN    = 1'b0;
        mosiEn = isStore_q;
      end
      ST_DONE: begin
        csN = 1'b1;
`ifdef NANOV_SPI_SEQ_FETCH_EN
        if (isFetch_q) begin
          csN = 1'b0;
        end
`endif
      end
`ifdef NANOV_SPI_SEQ_FETCH_EN
      ST_STREAM: begin
        ready = 1'b1;
        csN   = 1'b0;
      end
      ST_DESEL: csN = 1'b1;
`endif
      default: csN = 1'b1;
    endcase
  end

  assign bus.req_ready  = ready;
  assign bus.resp_valid = (state_q == ST_DONE);
  assign bus.resp_rdata = rdata_q;
  assign bus.spi_cs_n   = csN;
  assign bus.spi_sclk   = shSclk;
  assign bus.spi_mosi   = mosiEn & shSdo;

  // State and captured-request registers; reset abandons any transfer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      isStore_q   <= 1'b0;
      signExt_q   <= 1'b0;
      dataBits_q  <= WORD_BITS;
      addr_q      <= 24'd0;
      wdata_q     <= 32'd0;
      rdata_q     <= 32'd0;
`ifdef NANOV_SPI_SEQ_FETCH_EN
      isFetch_q   <= 1'b0;
      nextFetch_q <= 24'd0;
`endif
    end else begin
      state_q     <= state_d;
      isStore_q   <= isStore_d;
      signExt_q   <= signExt_d;
      dataBits_q  <= dataBits_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
`ifdef NANOV_SPI_SEQ_FETCH_EN
      isFetch_q   <= isFetch_d;
      nextFetch_q <= nextFetch_d;
`endif
    end
  end

endmodule

// File: tb/tb_nanov_spi_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_nanov_spi_mem_ctrl
// Self-checking bench: an SPI memory model answers the controller, and a
// transaction-level reference (byte array + arithmetic) predicts read data,
// wire bytes, latency and chip-select behaviour.
// Optional feature macro: NANOV_SPI_SEQ_FETCH_EN (reference follows it).
// ---------------------------------------------------------------------------
module tb_nanov_spi_mem_ctrl;

`ifdef NANOV_SPI_SEQ_FETCH_EN
  localparam bit SEQ_EN = 1'b1;
`else
  localparam bit SEQ_EN = 1'b0;
`endif

  logic clk;
  logic rstn;

  nanov_spi_mem_ctrl_if #(.ADDR_BITS(24)) bus ();

  nanov_spi_mem_ctrl #(.ADDR_BITS(24)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int checkCount;
  int errorCount;

  logic [7:0]  refMem   [0:4095];
  logic [7:0]  slaveMem [0:4095];
  logic        streamOn;
  logic [23:0] streamNext;

  int          bitCnt;
  int          slvK;
  logic [7:0]  rxByte;
  logic [7:0]  slvCmd;
  logic [23:0] slvAddr;
  logic [7:0]  slvTmp;
  logic [7:0]  mosiLog [$];

  // Free-running system clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SPI memory model, evaluated mid-cycle: logs MOSI bytes during phase B,
  // presents the next read bit on MISO during phase A, and writes store
  // data into its own array.
  always @(negedge clk) begin
    if (bus.spi_cs_n) begin
      bitCnt = 0;
    end else if (bus.spi_sclk) begin
      if (bitCnt == 0) mosiLog.delete();
      rxByte = {rxByte[6:0], bus.spi_mosi};
      bitCnt++;
      if (bitCnt % 8 == 0) begin
        mosiLog.push_back(rxByte);
        if (bitCnt == 8) slvCmd = rxByte;
        else if (bitCnt <= 32) slvAddr = {slvAddr[15:0], rxByte};
        else if (slvCmd == 8'h02) slaveMem[12'(slvAddr + 24'((bitCnt - 40) / 8))] = rxByte;
      end
    end else begin
      if (bitCnt >= 32 && slvCmd == 8'h03) begin
        slvK = bitCnt - 32;
        slvTmp = slaveMem[12'(slvAddr + 24'(slvK / 8))];
        bus.spi_miso = slvTmp[7 - (slvK % 8)];
      end else begin
        bus.spi_miso = 1'($urandom_range(0, 1));
      end
    end
  end

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic presetByte(input logic [23:0] a, input logic [7:0] v);
    refMem[a[11:0]]   = v;
    slaveMem[a[11:0]] = v;
  endtask

  // Issues one request and checks it against the transaction-level reference.
  task automatic applyStimulus(input logic fetch, input logic store, input logic [1:0] size,
                               input logic uns, input logic [23:0] addr, input logic [31:0] wdata);
    int          len;
    int          expLat;
    int          lat;
    int          w;
    int          csHigh;
    logic        isStore;
    logic        expSeq;
    logic        expDesel;
    logic        expCsDone;
    logic [7:0]  cmd;
    logic [63:0] v;
    logic [63:0] got;
    logic [31:0] expData;

    isStore = store && !fetch;
    len = fetch ? 4 : (size == 2'b00 ? 1 : (size == 2'b01 ? 2 : 4));
    cmd = isStore ? 8'h02 : 8'h03;

    v = 64'd0;
    for (int k = 0; k < len; k++) v += 64'(refMem[12'(addr + 24'(k))]) << (8 * k);
    if (!fetch && !uns && len < 4 && v >= (64'd1 << (8 * len - 1))) v = v - (64'd1 << (8 * len));
    expData = isStore ? 32'd0 : v[31:0];

    expSeq = 1'b0;
    expDesel = 1'b0;
    if (SEQ_EN && streamOn) begin
      if (fetch && addr == streamNext) expSeq = 1'b1;
      else expDesel = 1'b1;
    end
    expLat = expSeq ? 65 : 1 + 2 * (32 + 8 * len) + (expDesel ? 1 : 0);
    expCsDone = !(SEQ_EN && fetch);

    w = 0;
    while (!bus.req_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    checkOutput("ready_before", 64'(bus.req_ready), 64'd1);

    bus.req_valid    = 1'b1;
    bus.req_fetch    = fetch;
    bus.req_store    = store;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_wdata = ~wdata;
    bus.req_addr  = ~addr;
    lat = 1;
    checkOutput("cs_first", 64'(bus.spi_cs_n), 64'(expDesel));
    csHigh = 0;
    while (!bus.resp_valid && lat < 400) begin
      if (bus.spi_cs_n) csHigh++;
      @(negedge clk);
      lat++;
    end
    checkOutput("latency", 64'(lat), 64'(expLat));
    checkOutput("cs_high_mid", 64'(csHigh), 64'(expDesel ? 1 : 0));
    checkOutput("rdata", 64'(bus.resp_rdata), 64'(expData));
    checkOutput("cs_done", 64'(bus.spi_cs_n), 64'(expCsDone));

    if (!expSeq) begin
      got = (mosiLog.size() >= 4) ? 64'({mosiLog[0], mosiLog[1], mosiLog[2], mosiLog[3]}) : 64'd0;
      checkOutput("mosi_header", got, 64'({cmd, addr}));
      checkOutput("wire_bytes", 64'(mosiLog.size()), 64'(4 + len));
      if (isStore) begin
        got = 64'd0;
        for (int k = 0; k < len; k++)
          if (4 + k < mosiLog.size()) got |= 64'(mosiLog[4 + k]) << (8 * k);
        checkOutput("mosi_wdata", got, 64'(wdata) & ((64'd1 << (8 * len)) - 64'd1));
      end
    end

    if (isStore)
      for (int k = 0; k < len; k++) refMem[12'(addr + 24'(k))] = wdata[8 * k +: 8];
    streamOn   = SEQ_EN && fetch;
    streamNext = addr + 24'd4;

    @(negedge clk);
    checkOutput("ready_after", 64'(bus.req_ready), 64'd1);
    checkOutput("cs_after", 64'(bus.spi_cs_n), 64'(expCsDone));
    checkOutput("resp_pulse", 64'(bus.resp_valid), 64'd0);
  endtask

  // Hard stop in case the controller wedges in a way the bounded waits miss.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic        f;
    logic        s;
    logic        u;
    logic [1:0]  sz;
    logic [23:0] a;

    checkCount   = 0;
    errorCount   = 0;
    streamOn     = 1'b0;
    streamNext   = 24'd0;
    bitCnt       = 0;
    rxByte       = 8'd0;
    slvCmd       = 8'd0;
    slvAddr      = 24'd0;
    bus.spi_miso = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      refMem[i]   = 8'($urandom_range(0, 255));
      slaveMem[i] = refMem[i];
    end

    bus.req_valid    = 1'b0;
    bus.req_fetch    = 1'b0;
    bus.req_store    = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 24'd0;
    bus.req_wdata    = 32'd0;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_cs", 64'(bus.spi_cs_n), 64'd1);
    checkOutput("rst_sclk", 64'(bus.spi_sclk), 64'd0);
    checkOutput("rst_resp", 64'(bus.resp_valid), 64'd0);
    checkOutput("rst_rdata", 64'(bus.resp_rdata), 64'd0);
    rstn = 1'b1;
    @(negedge clk);

    $display("[TB] directed: word fetch 0x000100");
    presetByte(24'h000100, 8'h11);
    presetByte(24'h000101, 8'h22);
    presetByte(24'h000102, 8'h33);
    presetByte(24'h000103, 8'h44);
    applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 24'h000100, 32'h0);
    checkOutput("tp_fetch", 64'(bus.resp_rdata), 64'h44332211);

    $display("[TB] directed: byte/half loads at 0x000005");
    presetByte(24'h000005, 8'h80);
    presetByte(24'h000006, 8'h7F);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 24'h000005, 32'h0);
    checkOutput("tp_lb", 64'(bus.resp_rdata), 64'hFFFFFF80);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b1, 24'h000005, 32'h0);
    checkOutput("tp_lbu", 64'(bus.resp_rdata), 64'h00000080);
    applyStimulus(1'b0, 1'b0, 2'b01, 1'b0, 24'h000005, 32'h0);
    checkOutput("tp_lh", 64'(bus.resp_rdata), 64'h00007F80);

    $display("[TB] directed: half store 0xDEADBEEF at 0x000010");
    applyStimulus(1'b0, 1'b1, 2'b01, 1'b0, 24'h000010, 32'hDEADBEEF);
    checkOutput("tp_sh", 64'(bus.resp_rdata), 64'h0);
    applyStimulus(1'b0, 1'b0, 2'b01, 1'b0, 24'h000010, 32'h0);
    checkOutput("tp_sh_readback", 64'(bus.resp_rdata), 64'hFFFFBEEF);
    applyStimulus(1'b0, 1'b0, 2'b11, 1'b0, 24'h000010, 32'h0);

    $display("[TB] directed: fetch sequence 0x0, 0x4, 0x20");
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 24'h000000, 32'h0);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 24'h000004, 32'h0);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 24'h000020, 32'h0);

    $display("[TB] directed: reset during ADDR");
    bus.req_valid    = 1'b1;
    bus.req_fetch    = 1'b0;
    bus.req_store    = 1'b0;
    bus.req_size     = 2'b10;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 24'h000123;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (30) @(negedge clk);
    rstn = 1'b0;
    #1;
    checkOutput("midrst_cs", 64'(bus.spi_cs_n), 64'd1);
    checkOutput("midrst_sclk", 64'(bus.spi_sclk), 64'd0);
    checkOutput("midrst_mosi", 64'(bus.spi_mosi), 64'd0);
    checkOutput("midrst_resp", 64'(bus.resp_valid), 64'd0);
    checkOutput("midrst_rdata", 64'(bus.resp_rdata), 64'd0);
    streamOn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checkOutput("postrst_ready", 64'(bus.req_ready), 64'd1);
    applyStimulus(1'b0, 1'b0, 2'b10, 1'b0, 24'h000100, 32'h0);
    checkOutput("postrst_word", 64'(bus.resp_rdata), 64'h44332211);

    $display("[TB] random transactions");
    for (int i = 0; i < 40; i++) begin
      f  = ($urandom_range(0, 3) == 0);
      s  = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      u  = 1'($urandom_range(0, 1));
      a  = 24'($urandom_range(0, 511));
      if ($urandom_range(0, 7) == 0) a = a | 24'hFFF000;
      if (f && streamOn && $urandom_range(0, 1) == 1) a = streamNext;
      applyStimulus(f, s, sz, u, a, 32'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
